// File: rtl/mc6847x_pkg.sv
// mc6847x_pkg: sequencer state encoding and display mode geometry
package mc6847x_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LINE_END, DONE} seq_state_t;
  localparam int DEFAULT_ALPHA_ROWS = 12;
  localparam logic [5:0] WIDTH_SHORT = 6'd16;
  localparam logic [5:0] WIDTH_LONG = 6'd32;
  localparam logic [3:0] REP_ALPHA = 4'd12;
  function automatic logic [5:0] mode_width(input logic ang, input logic [2:0] gm);
    return (!ang || gm == 3'd2 || gm == 3'd4 || gm >= 3'd6) ? WIDTH_LONG : WIDTH_SHORT;
  endfunction
  function automatic logic [3:0] mode_repeat(input logic ang, input logic [2:0] gm);
    return !ang ? REP_ALPHA : gm <= 3'd2 ? 4'd3 : gm <= 3'd4 ? 4'd2 : 4'd1;
  endfunction
endpackage

// File: rtl/video_address_sequencer_if.sv
// video_address_sequencer_if: timing strobes and mode in, VRAM address and row status out
interface video_address_sequencer_if #(parameter int ADDR_WIDTH = 13);
  logic field_start, line_start, fetch, AnG;
  logic [2:0] GM;
  logic [ADDR_WIDTH-1:0] DA;
  logic [3:0] row;
  logic RP, line_active, frame_done;
  modport master(output field_start, line_start, fetch, AnG, GM,
                 input DA, row, RP, line_active, frame_done);
  modport slave(input field_start, line_start, fetch, AnG, GM,
                output DA, row, RP, line_active, frame_done);
endinterface

// File: rtl/video_mode_decode.sv
// video_mode_decode: AnG/GM to bytes per line and scanlines per fetched row
module video_mode_decode
  import mc6847x_pkg::*;
(
  input  logic       AnG,
  input  logic [2:0] GM,
  output logic [5:0] width,
  output logic [3:0] rpt
);
  assign width = mode_width(AnG, GM);
  assign rpt = mode_repeat(AnG, GM);
endmodule

// File: rtl/video_address_sequencer.sv
// video_address_sequencer: MC6847X display address, row repeat and alpha row counter
module video_address_sequencer
  import mc6847x_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int ACTIVE_LINES = 192,
  parameter int ALPHA_ROWS = DEFAULT_ALPHA_ROWS
) (
  input logic clk,
  input logic reset,
  video_address_sequencer_if.slave bus
);
  localparam int LW = $clog2(ACTIVE_LINES + 1);
  seq_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] da, base, base_n;
  logic [5:0] width, width_q, byte_cnt;
  logic [3:0] rpt, rpt_q, rep_cnt, row;
  logic [LW-1:0] line_cnt;
  logic rp, pend, start, take, last, rep_wrap;
  video_mode_decode u_decode (.AnG(bus.AnG), .GM(bus.GM), .width(width), .rpt(rpt));
  assign last = line_cnt == LW'(ACTIVE_LINES - 1);
  assign rep_wrap = rep_cnt == rpt_q - 4'd1;
  assign base_n = rep_wrap ? base + ADDR_WIDTH'(width_q) : base;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // An early line_start ends the line through LINE_END and is remembered in pend
  always_comb begin
    state_n = state;
    start = 1'b0;
    take = 1'b0;
    if (bus.field_start) state_n = IDLE;
    else if (state == IDLE) begin
      start = bus.line_start && line_cnt < LW'(ACTIVE_LINES);
      state_n = start ? FETCH : IDLE;
    end else if (state == FETCH) begin
      take = bus.fetch && !bus.line_start;
      state_n = (bus.line_start || (take && byte_cnt == width_q - 6'd1)) ? LINE_END : FETCH;
    end else if (state == LINE_END) begin
      start = !last && (pend || bus.line_start);
      state_n = last ? DONE : start ? FETCH : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || bus.field_start) begin
      da <= '0;
      base <= '0;
      byte_cnt <= '0;
      rep_cnt <= '0;
      line_cnt <= '0;
      row <= '0;
      rp <= 1'b0;
      pend <= 1'b0;
      width_q <= '0;
      rpt_q <= '0;
    end else begin
      rp <= 1'b0;
      if (start) begin
        width_q <= width;
        rpt_q <= rpt;
        byte_cnt <= '0;
      end
      if (take) begin
        da <= da + ADDR_WIDTH'(1);
        byte_cnt <= byte_cnt + 6'd1;
      end
      if (state == FETCH && bus.line_start) pend <= 1'b1;
      if (state == LINE_END) begin
        base <= base_n;
        da <= base_n;
        rep_cnt <= rep_wrap ? 4'd0 : rep_cnt + 4'd1;
        line_cnt <= line_cnt + LW'(1);
        row <= row == 4'(ALPHA_ROWS - 1) ? 4'd0 : row + 4'd1;
        rp <= row == 4'(ALPHA_ROWS - 1);
        pend <= 1'b0;
      end
    end
  end
  assign bus.DA = da;
  assign bus.row = row;
  assign bus.RP = rp;
  assign bus.line_active = state == FETCH;
  assign bus.frame_done = state == LINE_END && last;
endmodule

// File: tb/tb_video_address_sequencer.sv
// tb_video_address_sequencer: scoreboard of expected line start/end addresses, rows, RP and frame_done
module tb_video_address_sequencer;
  typedef struct packed {logic [12:0] da; logic [3:0] row; logic flag;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  ev_t start_q[$];
  ev_t end_q[$];
  logic prev_la = 1'b0;
  logic rp_seen = 1'b0;
  video_address_sequencer_if #(.ADDR_WIDTH(13)) bus ();
  video_address_sequencer #(.ADDR_WIDTH(13), .ACTIVE_LINES(192), .ALPHA_ROWS(12)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_ev(input string name, input ev_t act, input ev_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got DA=%0d row=%0d flag=%0b expected DA=%0d row=%0d flag=%0b",
               name, act.da, act.row, act.flag, exp.da, exp.row, exp.flag);
    end
  endtask
  function automatic ev_t ev(input int da, input int row, input bit f);
    return {13'(da), 4'(row), f};
  endfunction
  // Line start flag = RP seen since previous line start; line end flag = frame_done
  always @(negedge clk) begin : monitor
    ev_t a;
    if (reset || bus.field_start) rp_seen = 1'b0;
    if (bus.RP) rp_seen = 1'b1;
    if (bus.line_active !== prev_la) begin
      a = {bus.DA, bus.row, bus.line_active ? rp_seen : bus.frame_done};
      if (bus.line_active) begin
        if (start_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected line start: got DA=%0d row=%0d", a.da, a.row);
        end else check_ev("line start", a, start_q.pop_front());
        rp_seen = 1'b0;
      end else begin
        if (end_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected line end: got DA=%0d row=%0d", a.da, a.row);
        end else check_ev("line end", a, end_q.pop_front());
      end
    end
    prev_la = bus.line_active;
  end
  task automatic run_line(input int n);
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    bus.fetch = 1'b1;
    repeat (n) tick;
    bus.fetch = 1'b0;
    repeat (3) tick;
  endtask
  task automatic pulse_field(input logic ang, input logic [2:0] gm);
    bus.AnG = ang;
    bus.GM = gm;
    bus.field_start = 1'b1;
    tick;
    bus.field_start = 1'b0;
    tick;
  endtask
  task automatic run_frame(input logic ang, input logic [2:0] gm, input int w, input int r);
    pulse_field(ang, gm);
    for (int l = 0; l < 192; l++) begin
      start_q.push_back(ev(l / r * w, l % 12, l > 0 && l % 12 == 0));
      end_q.push_back(ev(l / r * w + w, l % 12, l == 191));
      run_line(w);
    end
  endtask
  initial begin
    bus.field_start = 1'b0;
    bus.line_start = 1'b0;
    bus.fetch = 1'b0;
    bus.AnG = 1'b1;
    bus.GM = 3'd6;
    repeat (2) tick;
    check("reset DA", int'(bus.DA), 0);
    check("reset row", int'(bus.row), 0);
    check("reset RP", int'(bus.RP), 0);
    check("reset line_active", int'(bus.line_active), 0);
    check("reset frame_done", int'(bus.frame_done), 0);
    reset = 1'b0;
    tick;
    run_frame(1'b1, 3'd6, 32, 1);
    check("GM6 final DA", int'(bus.DA), 6144);
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    check("DONE ignores line_start", int'(bus.line_active), 0);
    run_frame(1'b1, 3'd3, 16, 2);
    check("GM3 final DA", int'(bus.DA), 1536);
    run_frame(1'b1, 3'd0, 16, 3);
    check("GM0 final DA", int'(bus.DA), 1024);
    run_frame(1'b0, 3'd5, 32, 12);
    check("alpha final DA", int'(bus.DA), 512);
    // field_start in the middle of line 2
    pulse_field(1'b1, 3'd6);
    for (int l = 0; l < 2; l++) begin
      start_q.push_back(ev(l * 32, l, 1'b0));
      end_q.push_back(ev(l * 32 + 32, l, 1'b0));
      run_line(32);
    end
    start_q.push_back(ev(64, 2, 1'b0));
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    bus.fetch = 1'b1;
    repeat (5) tick;
    check("mid-line DA", int'(bus.DA), 69);
    end_q.push_back(ev(0, 0, 1'b0));
    bus.field_start = 1'b1;
    tick;
    bus.field_start = 1'b0;
    bus.fetch = 1'b0;
    check("field_start DA", int'(bus.DA), 0);
    check("field_start row", int'(bus.row), 0);
    tick;
    // fetch with line_start is dropped; 40 fetches stop at 32
    start_q.push_back(ev(0, 0, 1'b0));
    end_q.push_back(ev(32, 0, 1'b0));
    bus.line_start = 1'b1;
    bus.fetch = 1'b1;
    tick;
    bus.line_start = 1'b0;
    repeat (40) tick;
    bus.fetch = 1'b0;
    tick;
    check("overfetch DA", int'(bus.DA), 32);
    // line_start after 10 fetches aborts the line and starts the next one
    start_q.push_back(ev(32, 1, 1'b0));
    end_q.push_back(ev(42, 1, 1'b0));
    start_q.push_back(ev(64, 2, 1'b0));
    end_q.push_back(ev(96, 2, 1'b0));
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    bus.fetch = 1'b1;
    repeat (10) tick;
    bus.fetch = 1'b0;
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    tick;
    bus.fetch = 1'b1;
    repeat (32) tick;
    bus.fetch = 1'b0;
    repeat (3) tick;
    check("abort DA", int'(bus.DA), 96);
    // GM5 -> GM6 mid-line keeps width 16 for the current line
    pulse_field(1'b1, 3'd5);
    start_q.push_back(ev(0, 0, 1'b0));
    end_q.push_back(ev(16, 0, 1'b0));
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    bus.fetch = 1'b1;
    repeat (8) tick;
    bus.GM = 3'd6;
    repeat (8) tick;
    bus.fetch = 1'b0;
    repeat (3) tick;
    check("mode change base", int'(bus.DA), 16);
    start_q.push_back(ev(16, 1, 1'b0));
    end_q.push_back(ev(48, 1, 1'b0));
    run_line(32);
    // reset during line 2
    start_q.push_back(ev(48, 2, 1'b0));
    end_q.push_back(ev(0, 0, 1'b0));
    bus.line_start = 1'b1;
    tick;
    bus.line_start = 1'b0;
    bus.fetch = 1'b1;
    repeat (5) tick;
    reset = 1'b1;
    tick;
    check("mid-line reset DA", int'(bus.DA), 0);
    check("mid-line reset row", int'(bus.row), 0);
    check("mid-line reset RP", int'(bus.RP), 0);
    check("mid-line reset line_active", int'(bus.line_active), 0);
    check("mid-line reset frame_done", int'(bus.frame_done), 0);
    reset = 1'b0;
    bus.fetch = 1'b0;
    repeat (3) tick;
    check("start queue drained", start_q.size(), 0);
    check("end queue drained", end_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
